writeback_stage: RTL

//   Final pipeline stage: accepts retiring instructions from the memory stage, selects ALU

---
 rtl/writeback_stage_pkg.sv | 20 ++
 rtl/writeback_stage_load_timer.sv | 29 ++
 rtl/writeback_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage.
// Bus layout: {wb strobe, data, register address}.
package writeback_stage_pkg;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_LOAD_TIMEOUT = 15;

  localparam int WB_BIT   = 19;
  localparam int DATA_MSB = 18;
  localparam int DATA_LSB = 3;
  localparam int ADDR_MSB = 2;
  localparam int ADDR_LSB = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/writeback_stage_load_timer.sv
// Load wait timer: cleared counter with enable.
// Ports: Clk, Rst (sync, active-low), clear, enable, tc (count == TIMEOUT-1).
module wb_load_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects ALU or load data and drives the writeback bus.
// Ports: Clk/Rst, in_* handshake + fields, mem_rdata(_valid), writeback, pending_*, load_err, retired_count.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wb_en,
  input  logic                     in_mem_to_reg,
  input  logic [ADDR_W-1:0]        in_rdst,
  input  logic [DATA_W-1:0]        in_alu_result,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rdata_valid,
  output logic [DATA_W+ADDR_W:0]   writeback,
  output logic                     pending_valid,
  output logic [ADDR_W-1:0]        pending_rdst,
  output logic                     load_err,
  output logic [15:0]              retired_count
);

  localparam int WB_W = DATA_W + ADDR_W + 1;

  state_t            state;
  state_t            state_n;
  logic [WB_W-1:0]   wb_q;
  logic [WB_W-1:0]   wb_n;
  logic [ADDR_W-1:0] rdst_q;
  logic [ADDR_W-1:0] rdst_n;
  logic              err_q;
  logic              err_n;
  logic [15:0]       retired_q;
  logic              retire;
  logic              t_clear;
  logic              t_en;
  logic              t_tc;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign sel_data = in_mem_to_reg ? mem_rdata : in_alu_result;

  wb_load_timer #(
    .TIMEOUT (LOAD_TIMEOUT)
  ) u_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .clear  (t_clear),
    .enable (t_en),
    .tc     (t_tc)
  );

  always_comb begin
    state_n = state;
    // strobe drops by default; payload holds the last value
    wb_n    = {1'b0, wb_q[WB_W-2:0]};
    rdst_n  = rdst_q;
    err_n   = 1'b0;
    retire  = 1'b0;
    t_clear = 1'b0;
    t_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        t_clear = 1'b1;
        if (accept) begin
          if (in_mem_to_reg & in_wb_en & ~mem_rdata_valid) begin
            state_n = S_WAIT;
            rdst_n  = in_rdst;
          end else begin
            wb_n   = {in_wb_en, sel_data, in_rdst};
            retire = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mem_rdata_valid) begin
          wb_n    = {1'b1, mem_rdata, rdst_q};
          retire  = 1'b1;
          state_n = S_IDLE;
        end else if (t_tc) begin
          err_n   = 1'b1;
          retire  = 1'b1;
          state_n = S_IDLE;
        end else begin
          t_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_IDLE;
      wb_q      <= '0;
      rdst_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state  <= state_n;
      wb_q   <= wb_n;
      rdst_q <= rdst_n;
      err_q  <= err_n;
      if (retire) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign writeback     = wb_q;
  assign load_err      = err_q;
  assign retired_count = retired_q;
  assign pending_valid = (state == S_WAIT);
  assign pending_rdst  = (state == S_WAIT) ? rdst_q : '0;

endmodule
